// File: rtl/reset_sequencer.sv
// Staged reset release for the pixel clock domain: qualifies PLL lock, then de-asserts
// NUM_RESETS active-low resets in index order, re-running on lock loss or a soft request.
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILTER = 8,
    parameter int HOLD_CYCLES = 15,
    parameter int NUM_RESETS  = 3,
    parameter int STAGE_GAP   = 4,
    parameter int CNT_W       = 8
) (
    input  logic                  clk_pixel,
    input  logic                  ext_reset,
    input  logic                  pll_lock,
    input  logic                  soft_req,
    output logic [NUM_RESETS-1:0] resetn_out,
    output logic                  seq_done,
    output logic [1:0]            state,
    output logic [CNT_W-1:0]      lock_loss_cnt
);

    localparam int LOCK_W = $clog2(LOCK_FILTER + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int GAP_W  = $clog2(STAGE_GAP + 1);

    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_FILTER - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    lock_s;
    logic [LOCK_W-1:0]       lock_cnt_q, lock_cnt_d;
    logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
    logic [NUM_RESETS-1:0]   resetn_q, resetn_d;
    logic [NUM_RESETS-1:0]   resetn_step;
    logic                    done_q, done_d;
    logic [CNT_W-1:0]        loss_cnt_q, loss_cnt_d;

    always_ff @(posedge clk_pixel or negedge ext_reset) begin
        if (!ext_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    // Releasing one more bit shifts the released mask up by one, so bits free in index order.
    assign resetn_step = NUM_RESETS'({resetn_q, 1'b1});

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        resetn_d   = resetn_q;
        done_d     = done_q;
        loss_cnt_d = loss_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (!lock_s) begin
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    lock_cnt_d = '0;
                    hold_cnt_d = '0;
                    state_d    = ST_HOLD;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    gap_cnt_d  = '0;
                    resetn_d   = resetn_step;
                    if (&resetn_step) begin
                        done_d  = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_RELEASE: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    resetn_d  = resetn_step;
                    if (&resetn_step) begin
                        done_d  = 1'b1;
                        state_d = ST_RUN;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            ST_RUN: begin
                if (soft_req) begin
                    resetn_d   = '0;
                    done_d     = 1'b0;
                    hold_cnt_d = '0;
                    gap_cnt_d  = '0;
                    state_d    = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Lock loss outranks soft requests and progress; IDLE is still waiting for lock.
        if (state_q != ST_IDLE && !lock_s) begin
            state_d    = ST_IDLE;
            lock_cnt_d = '0;
            hold_cnt_d = '0;
            gap_cnt_d  = '0;
            resetn_d   = '0;
            done_d     = 1'b0;
            if (loss_cnt_q != '1) begin
                loss_cnt_d = loss_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge ext_reset) begin
        if (!ext_reset) begin
            state_q    <= ST_IDLE;
            lock_cnt_q <= '0;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            resetn_q   <= '0;
            done_q     <= 1'b0;
            loss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            resetn_q   <= resetn_d;
            done_q     <= done_d;
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign resetn_out    = resetn_q;
    assign seq_done      = done_q;
    assign state         = state_q;
    assign lock_loss_cnt = loss_cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: three configurations share one stimulus stream and are checked
// against spec latencies and an edge-counting reference model.
module tb_reset_sequencer;

    logic clk_pixel = 1'b0;
    logic ext_reset = 1'b0;
    logic pll_lock  = 1'b1;
    logic soft_req  = 1'b0;

    logic [2:0] rn_a;  logic done_a;  logic [1:0] st_a;  logic [7:0] cnt_a;
    logic [2:0] rn_b;  logic done_b;  logic [1:0] st_b;  logic [1:0] cnt_b;
    logic [0:0] rn_c;  logic done_c;  logic [1:0] st_c;  logic [7:0] cnt_c;

    int errors = 0;
    int checks = 0;

    always #5 clk_pixel = ~clk_pixel;

    reset_sequencer u_dut_a (
        .clk_pixel(clk_pixel), .ext_reset(ext_reset), .pll_lock(pll_lock), .soft_req(soft_req),
        .resetn_out(rn_a), .seq_done(done_a), .state(st_a), .lock_loss_cnt(cnt_a)
    );

    reset_sequencer #(.CNT_W(2)) u_dut_b (
        .clk_pixel(clk_pixel), .ext_reset(ext_reset), .pll_lock(pll_lock), .soft_req(soft_req),
        .resetn_out(rn_b), .seq_done(done_b), .state(st_b), .lock_loss_cnt(cnt_b)
    );

    reset_sequencer #(.NUM_RESETS(1), .STAGE_GAP(1), .HOLD_CYCLES(1)) u_dut_c (
        .clk_pixel(clk_pixel), .ext_reset(ext_reset), .pll_lock(pll_lock), .soft_req(soft_req),
        .resetn_out(rn_c), .seq_done(done_c), .state(st_c), .lock_loss_cnt(cnt_c)
    );

    // Reference model: per instance, either waiting for lock or "k edges since HOLD entry",
    // from which the released-bit count follows arithmetically.
    localparam int LF        = 8;
    localparam int HOLD_P[3] = '{15, 15, 1};
    localparam int GAP_P[3]  = '{4, 4, 1};
    localparam int N_P[3]    = '{3, 3, 1};
    localparam int MAXC[3]   = '{255, 3, 255};

    int       edge_n   = 0;
    bit [1:0] hist     = 2'b00;
    bit       m_idle[3] = '{1'b1, 1'b1, 1'b1};
    int       m_run[3]   = '{0, 0, 0};
    int       m_entry[3] = '{0, 0, 0};
    int       m_loss[3]  = '{0, 0, 0};

    function automatic int run_at(input int i);
        return HOLD_P[i] + (N_P[i] - 1) * GAP_P[i];
    endfunction

    always @(posedge clk_pixel or negedge ext_reset) begin
        if (!ext_reset) begin
            edge_n <= 0;
            hist   <= 2'b00;
            for (int i = 0; i < 3; i++) begin
                m_idle[i]  <= 1'b1;
                m_run[i]   <= 0;
                m_entry[i] <= 0;
                m_loss[i]  <= 0;
            end
        end else begin
            edge_n <= edge_n + 1;
            hist   <= {hist[0], pll_lock};
            for (int i = 0; i < 3; i++) begin
                if (m_idle[i]) begin
                    if (!hist[1]) begin
                        m_run[i] <= 0;
                    end else if (m_run[i] + 1 == LF) begin
                        m_idle[i]  <= 1'b0;
                        m_entry[i] <= edge_n + 1;
                        m_run[i]   <= 0;
                    end else begin
                        m_run[i] <= m_run[i] + 1;
                    end
                end else if (!hist[1]) begin
                    m_idle[i] <= 1'b1;
                    m_run[i]  <= 0;
                    if (m_loss[i] < MAXC[i]) m_loss[i] <= m_loss[i] + 1;
                end else if (soft_req && (edge_n - m_entry[i]) >= run_at(i)) begin
                    m_entry[i] <= edge_n + 1;
                end
            end
        end
    end

    function automatic logic [13:0] exp_vec(input int i);
        int k;
        int r;
        logic [1:0] st;
        if (m_idle[i]) return {2'd0, 1'b0, 3'd0, 8'(m_loss[i])};
        k = edge_n - m_entry[i];
        r = (k < HOLD_P[i]) ? 0 : 1 + (k - HOLD_P[i]) / GAP_P[i];
        if (r > N_P[i]) r = N_P[i];
        st = (k < HOLD_P[i]) ? 2'd1 : (r < N_P[i]) ? 2'd2 : 2'd3;
        return {st, r == N_P[i], 3'((1 << r) - 1), 8'(m_loss[i])};
    endfunction

    function automatic logic [13:0] obs_vec(input int i);
        case (i)
            0:       return {st_a, done_a, rn_a, cnt_a};
            1:       return {st_b, done_b, rn_b, 6'd0, cnt_b};
            default: return {st_c, done_c, 2'b00, rn_c, cnt_c};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic test_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_vec(i) !== 14'd0) begin
                errors++;
                $display("FAIL reset inst%0d got %h want %h", i, obs_vec(i), 14'd0);
            end
        end
    endtask

    task automatic test_power_up();
        logic [1:0] st_e;
        logic [2:0] rn_e;
        #1;
        ext_reset = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            st_e = (e < 10) ? 2'd0 : (e < 25) ? 2'd1 : (e < 33) ? 2'd2 : 2'd3;
            rn_e = (e < 25) ? 3'b000 : (e < 29) ? 3'b001 : (e < 33) ? 3'b011 : 3'b111;
            checks++;
            if ({st_a, done_a, rn_a} !== {st_e, e >= 33, rn_e}) begin
                errors++;
                $display("FAIL power_up edge%0d got st=%0d done=%b rn=%b want st=%0d done=%b rn=%b",
                         e, st_a, done_a, rn_a, st_e, e >= 33, rn_e);
            end
            st_e = (e < 10) ? 2'd0 : (e == 10) ? 2'd1 : 2'd3;
            checks++;
            if ({st_c, done_c, rn_c} !== {st_e, e >= 11, e >= 11}) begin
                errors++;
                $display("FAIL single_stage edge%0d got st=%0d done=%b rn=%b want st=%0d done=%b rn=%b",
                         e, st_c, done_c, rn_c, st_e, e >= 11, e >= 11);
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL power_up_model inst%0d edge%0d got %h want %h", i, edge_n, obs_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_idle_glitch();
        int since = 0;
        int p = 5;
        int lows = 0;
        ext_reset = 1'b0;
        tick();
        ext_reset = 1'b1;
        for (int c = 0; c < 70; c++) begin
            if (since == p - 1) begin
                pll_lock = 1'b0;
                since = 0;
                lows++;
                p = (lows < 6) ? 5 : $urandom_range(2, 8);
            end else begin
                pll_lock = 1'b1;
                since++;
            end
            tick();
            checks++;
            if ({st_a, done_a, rn_a} !== 6'd0) begin
                errors++;
                $display("FAIL idle_glitch edge%0d got st=%0d done=%b rn=%b want all 0", edge_n, st_a, done_a, rn_a);
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL idle_glitch_model inst%0d edge%0d got %h want %h", i, edge_n, obs_vec(i), exp_vec(i));
                end
            end
        end
        pll_lock = 1'b1;
    endtask

    task automatic test_lock_loss();
        int n;
        logic [1:0] st_e;
        logic [2:0] rn_e;
        n = 0;
        while (st_a !== 2'd3 && n < 100) begin
            tick();
            n++;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL lock_loss_model inst%0d edge%0d got %h want %h", i, edge_n, obs_vec(i), exp_vec(i));
                end
            end
        end
        checks++;
        if (st_a !== 2'd3 || cnt_a !== 8'd0) begin
            errors++;
            $display("FAIL lock_loss_start got st=%0d cnt=%0d want st=3 cnt=0", st_a, cnt_a);
        end
        repeat ($urandom_range(0, 5)) tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        tick();
        checks++;
        if (rn_a !== 3'b111 || st_a !== 2'd3) begin
            errors++;
            $display("FAIL lock_drop_early got rn=%b st=%0d want rn=111 st=3", rn_a, st_a);
        end
        tick();
        checks++;
        if ({rn_a, st_a, done_a, cnt_a, cnt_b} !== {3'b000, 2'd0, 1'b0, 8'd1, 2'd1}) begin
            errors++;
            $display("FAIL lock_drop got rn=%b st=%0d done=%b cnt=%0d cnt_b=%0d want rn=000 st=0 done=0 cnt=1 cnt_b=1",
                     rn_a, st_a, done_a, cnt_a, cnt_b);
        end
        for (int rel = 4; rel <= 34; rel++) begin
            tick();
            st_e = (rel < 11) ? 2'd0 : (rel < 26) ? 2'd1 : (rel < 34) ? 2'd2 : 2'd3;
            rn_e = (rel < 26) ? 3'b000 : (rel < 30) ? 3'b001 : (rel < 34) ? 3'b011 : 3'b111;
            checks++;
            if ({st_a, done_a, rn_a} !== {st_e, rel >= 34, rn_e}) begin
                errors++;
                $display("FAIL lock_rerun fall+%0d got st=%0d done=%b rn=%b want st=%0d done=%b rn=%b",
                         rel, st_a, done_a, rn_a, st_e, rel >= 34, rn_e);
            end
        end
        for (int j = 0; j < 4; j++) begin
            n = 0;
            while (st_a === 2'd0 && n < 50) begin
                tick();
                n++;
            end
            repeat ($urandom_range(0, 30)) begin
                tick();
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (obs_vec(i) !== exp_vec(i)) begin
                        errors++;
                        $display("FAIL loss_burst_model inst%0d edge%0d got %h want %h", i, edge_n, obs_vec(i), exp_vec(i));
                    end
                end
            end
            pll_lock = 1'b0;
            for (int t = 0; t < 3; t++) begin
                tick();
                pll_lock = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (obs_vec(i) !== exp_vec(i)) begin
                        errors++;
                        $display("FAIL loss_burst_model inst%0d edge%0d got %h want %h", i, edge_n, obs_vec(i), exp_vec(i));
                    end
                end
            end
        end
        checks++;
        if ({cnt_a, cnt_b, cnt_c} !== {8'd5, 2'd3, 8'd5}) begin
            errors++;
            $display("FAIL loss_saturate got cnt_a=%0d cnt_b=%0d cnt_c=%0d want 5 3 5", cnt_a, cnt_b, cnt_c);
        end
    endtask

    task automatic test_soft_req();
        int n;
        logic [1:0] st_e;
        logic [2:0] rn_e;
        n = 0;
        while (st_a !== 2'd3 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (st_a !== 2'd3) begin
            errors++;
            $display("FAIL soft_req_wait got st=%0d want 3", st_a);
        end
        repeat ($urandom_range(0, 3)) tick();
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        checks++;
        if (rn_a !== 3'b000 || st_a !== 2'd1 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL soft_req_assert got rn=%b st=%0d done=%b want rn=000 st=1 done=0", rn_a, st_a, done_a);
        end
        for (int rel = 1; rel <= 24; rel++) begin
            soft_req = (rel == 5);
            tick();
            soft_req = 1'b0;
            st_e = (rel < 15) ? 2'd1 : (rel < 23) ? 2'd2 : 2'd3;
            rn_e = (rel < 15) ? 3'b000 : (rel < 19) ? 3'b001 : (rel < 23) ? 3'b011 : 3'b111;
            checks++;
            if ({st_a, done_a, rn_a} !== {st_e, rel >= 23, rn_e}) begin
                errors++;
                $display("FAIL soft_req_seq E+%0d got st=%0d done=%b rn=%b want st=%0d done=%b rn=%b",
                         rel, st_a, done_a, rn_a, st_e, rel >= 23, rn_e);
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL soft_req_model inst%0d edge%0d got %h want %h", i, edge_n, obs_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int d;
        logic [1:0] st_e;
        logic [2:0] rn_e;
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        repeat (14 + $urandom_range(1, 8)) tick();
        checks++;
        if (st_a !== 2'd2) begin
            errors++;
            $display("FAIL async_pre got st=%0d want 2", st_a);
        end
        d = $urandom_range(1, 5);
        #d;
        ext_reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_vec(i) !== 14'd0) begin
                errors++;
                $display("FAIL async_clear inst%0d got %h want %h", i, obs_vec(i), 14'd0);
            end
        end
        #1;
        ext_reset = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            tick();
            st_e = (e < 10) ? 2'd0 : (e < 25) ? 2'd1 : (e < 33) ? 2'd2 : 2'd3;
            rn_e = (e < 25) ? 3'b000 : (e < 29) ? 3'b001 : (e < 33) ? 3'b011 : 3'b111;
            checks++;
            if ({st_a, done_a, rn_a, cnt_a} !== {st_e, e >= 33, rn_e, 8'd0}) begin
                errors++;
                $display("FAIL async_rerun edge%0d got st=%0d done=%b rn=%b cnt=%0d want st=%0d done=%b rn=%b cnt=0",
                         e, st_a, done_a, rn_a, cnt_a, st_e, e >= 33, rn_e);
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL async_model inst%0d edge%0d got %h want %h", i, edge_n, obs_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_random_mix();
        for (int c = 0; c < 300; c++) begin
            soft_req = ($urandom_range(0, 7) == 0);
            pll_lock = ($urandom_range(0, 39) != 0);
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL random_mix_model inst%0d edge%0d got %h want %h", i, edge_n, obs_vec(i), exp_vec(i));
                end
            end
        end
        soft_req = 1'b0;
        pll_lock = 1'b1;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_idle_glitch();
        test_lock_loss();
        test_soft_req();
        test_async_reset();
        test_random_mix();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "simulation did not complete");
    end

endmodule
